// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch direction predictor: counter encodings and default sizes.
package branch_predictor_pkg;

  localparam int BP_IDX_W = 6;
  localparam int BP_CNT_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-side signal bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = BP_CNT_W
);

  logic [31:0]      pc_F;
  logic             predict_en_F;
  logic [IDX_W-1:0] predict_idx_F;
  logic             branch_E;
  logic             branch_h_E;
  logic             predict_en_E;
  logic [IDX_W-1:0] predict_idx_E;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output pc_F, branch_E, branch_h_E, predict_en_E, predict_idx_E,
    input  predict_en_F, predict_idx_F, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  pc_F, branch_E, branch_h_E, predict_en_E, predict_idx_E,
    output predict_en_F, predict_idx_F, branch_cnt, mispredict_cnt
  );

endinterface

// File: rtl/branch_predictor_sat_ctr2.sv
// 2-bit saturating up/down counter; resets to weakly-not-taken.
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr_o
);

  ctr_e ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (inc && ctr_q != ST) begin
      ctr_d = ctr_e'(ctr_q + 2'd1);
    end else if (dec && ctr_q != SNT) begin
      ctr_d = ctr_e'(ctr_q - 2'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr_q <= WNT;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// Table of 2-bit counters with combinational F-stage lookup and E-stage training.
// Define BP_GSHARE_EN to XOR the index with a global history of resolved branches.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W,
  parameter int CNT_W = BP_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  branch_predictor_if.slave bp
);

  localparam int N = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [IDX_W-1:0] idx_f;
  logic [1:0]       ctr_val [N];
  logic [N-1:0]     inc_vec;
  logic [N-1:0]     dec_vec;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispredict_cnt_q, mispredict_cnt_d;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{bp.pc_F[31:IDX_W+2], bp.pc_F[1:0]};

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;

  // History is only advanced by resolved branches, never speculatively at F.
  always_comb begin
    ghr_d = ghr_q;
    if (bp.branch_E) begin
      ghr_d = {ghr_q[IDX_W-2:0], bp.branch_h_E};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign idx_f = bp.pc_F[IDX_W+1:2] ^ ghr_q;
`else
  assign idx_f = bp.pc_F[IDX_W+1:2];
`endif

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ctr
      assign inc_vec[gi] = bp.branch_E &&  bp.branch_h_E && (bp.predict_idx_E == IDX_W'(gi));
      assign dec_vec[gi] = bp.branch_E && !bp.branch_h_E && (bp.predict_idx_E == IDX_W'(gi));

      sat_ctr2 u_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (inc_vec[gi]),
        .dec   (dec_vec[gi]),
        .ctr_o (ctr_val[gi])
      );
    end
  endgenerate

  // Reads the registered counter, so a same-cycle update to this index is not bypassed.
  assign bp.predict_idx_F = idx_f;
  assign bp.predict_en_F  = ctr_val[idx_f][1];

  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (bp.branch_E) begin
      if (branch_cnt_q != CNT_MAX) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
      if ((bp.predict_en_E != bp.branch_h_E) && (mispredict_cnt_q != CNT_MAX)) begin
        mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign bp.branch_cnt     = branch_cnt_q;
  assign bp.mispredict_cnt = mispredict_cnt_q;

endmodule
